// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB codes, bridge state encoding and the AHB-to-APB protection mapping.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WDATA  = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_ACCESS = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ERR1   = 3'd5;
    localparam logic [2:0] ST_ERR2   = 3'd6;

    // hprot[0] is opcode/data, hprot[1] is privileged; APB wants {instr, nonsecure, priv}.
    function automatic logic [2:0] map_pprot(input logic [1:0] hprot_lo);
        return {~hprot_lo[0], 1'b0, hprot_lo[1]};
    endfunction

endpackage

// File: rtl/ahb_apb_strb_gen.sv
// Byte-lane strobes for a naturally aligned transfer of 2**hsize bytes at a lane offset.
module ahb_apb_strb_gen #(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int OFS_W  = $clog2(NB)
) (
    input  logic [2:0]       hsize,
    input  logic [OFS_W-1:0] offset,
    output logic [NB-1:0]    pstrb
);

    // A lane is enabled when it sits in the same size-aligned block as the offset.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        pstrb = '0;
        for (int i = 0; i < NB; i++) begin
            pstrb[i] = ((OFS_W'(i) >> hsize) == (offset >> hsize));
        end
    end

endmodule

// File: rtl/ahb_apb_bridge_mslv.sv
// AHB-Lite slave to multi-slave APB bridge: one outstanding transfer, slave picked by an address field.
module ahb_apb_bridge_mslv
    import ahb_apb_pkg::*;
#(
    parameter int NUM_SLV     = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int IDX_LSB     = 12,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic                      hsel,
    input  logic                      hready,
    input  logic [ADDR_W-1:0]         haddr,
    input  logic [1:0]                htrans,
    input  logic                      hwrite,
    input  logic [2:0]                hsize,
    input  logic [3:0]                hprot,
    input  logic [DATA_W-1:0]         hwdata,
    output logic                      hreadyout,
    output logic                      hresp,
    output logic [DATA_W-1:0]         hrdata,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    output logic [DATA_W/8-1:0]       pstrb,
    output logic [2:0]                pprot,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);

    localparam int NB    = DATA_W / 8;
    localparam int OFS_W = $clog2(NB);
    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [2:0]   MAX_SIZE  = 3'($clog2(NB));
    localparam logic [IDX_W:0] SLV_LIM = (IDX_W + 1)'(NUM_SLV);

    logic [2:0]        state, state_nxt, first_state;
    logic [IDX_W-1:0]  idx, idx_new;
    logic [TO_W-1:0]   to_cnt;
    logic [NB-1:0]     strb_new;
    logic [DATA_W-1:0] rd_sel;
    logic              accept, bad_req, sel_ready, sel_err, timed_out;
    logic              unused_hprot;

    assign unused_hprot = &{1'b0, hprot[3:2]};

    assign idx_new = haddr[IDX_LSB +: IDX_W];
    assign accept  = (state == ST_IDLE || state == ST_DONE) && hsel && hready &&
                     (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign bad_req = ({1'b0, idx_new} >= SLV_LIM) || (hsize > MAX_SIZE);
    assign first_state = bad_req ? ST_ERR1 : (hwrite ? ST_WDATA : ST_SETUP);
    assign timed_out   = (TIMEOUT_CYC != 0) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    ahb_apb_strb_gen #(.DATA_W(DATA_W)) u_strb_gen (
        .hsize  (hsize),
        .offset (haddr[OFS_W-1:0]),
        .pstrb  (strb_new)
    );

    // Only the addressed slave's handshake and read data are ever looked at.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        rd_sel    = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (IDX_W'(i) == idx) begin
                sel_ready = pready[i];
                sel_err   = pslverr[i];
                rd_sel    = prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: state_nxt = accept ? first_state : ST_IDLE;
            ST_WDATA:         state_nxt = ST_SETUP;
            ST_SETUP:         state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (sel_ready)      state_nxt = sel_err ? ST_ERR1 : ST_DONE;
                else if (timed_out) state_nxt = ST_ERR1;
            end
            ST_ERR1:          state_nxt = ST_ERR2;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (hreset) begin
            state  <= ST_IDLE;
            idx    <= '0;
            to_cnt <= '0;
            paddr  <= '0;
            pwrite <= 1'b0;
            pprot  <= '0;
            pstrb  <= '0;
            pwdata <= '0;
            hrdata <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx    <= idx_new;
                paddr  <= haddr;
                pwrite <= hwrite;
                pprot  <= map_pprot(hprot[1:0]);
                pstrb  <= hwrite ? strb_new : '0;
            end
            if (state == ST_WDATA) pwdata <= hwdata;
            if (state == ST_SETUP) begin
                to_cnt <= '0;
            end else if (state == ST_ACCESS && !sel_ready && !timed_out) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (state == ST_ACCESS && sel_ready && !pwrite) hrdata <= rd_sel;
        end
    end

    // Handshake outputs come straight from the state register, never from live inputs.
    always_comb begin
        hreadyout = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
        hresp     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
        penable   = (state == ST_ACCESS);
        psel      = '0;
        if (state == ST_SETUP || state == ST_ACCESS) begin
            for (int i = 0; i < NUM_SLV; i++) psel[i] = (IDX_W'(i) == idx);
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge_mslv.sv
// Randomised scoreboard bench: the driver predicts each transfer's response, a monitor checks it on completion.
module tb_ahb_apb_bridge_mslv;
    import ahb_apb_pkg::*;

    localparam int NUM_SLV = 3, ADDR_W = 16, DATA_W = 32, IDX_LSB = 12, TIMEOUT_CYC = 8;

    typedef struct {
        logic [15:0] addr;
        bit          write;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic [31:0] wdata;
        int          waits;
        bit          slverr;
        logic [31:0] rdata;
    } xfer_t;

    typedef struct {
        string       name;
        bit          err;
        int          low;
        logic [2:0]  psel;
        int          psel_cyc;
        int          pen_cyc;
        logic [31:0] hrdata;
        logic [31:0] pwdata;
        logic [15:0] paddr;
        bit          pwrite;
        logic [3:0]  pstrb;
        bit          chk_strb;
        logic [2:0]  pprot;
    } exp_t;

    logic        hclk = 1'b0, hreset = 1'b1, hsel = 1'b0, hwrite = 1'b0;
    logic        hready;
    logic [15:0] haddr = '0;
    logic [1:0]  htrans = '0;
    logic [2:0]  hsize = '0;
    logic [3:0]  hprot = '0;
    logic [31:0] hwdata = '0;
    logic        hreadyout, hresp, penable, pwrite;
    logic [31:0] hrdata, pwdata;
    logic [2:0]  psel, pprot;
    logic [15:0] paddr;
    logic [3:0]  pstrb;
    logic [95:0] prdata = '0;
    logic [2:0]  pready = '0, pslverr = '0;

    int chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;
    exp_t expq[$];
    logic [31:0] mdl_hrdata = '0, mdl_pwdata = '0;
    int cur_idx = 0, cur_waits = 0;
    bit cur_slverr = 0;
    logic [31:0] cur_rdata = '0;

    assign hready = hreadyout;
    always #5 hclk = ~hclk;

    ahb_apb_bridge_mslv #(
        .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .IDX_LSB(IDX_LSB), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .hready(hready), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_hreadyout"}, 64'(hreadyout), 64'd1);
        check({tag, "_hresp"},     64'(hresp),     64'd0);
        check({tag, "_psel"},      64'(psel),      64'd0);
        check({tag, "_penable"},   64'(penable),   64'd0);
        check({tag, "_paddr"},     64'(paddr),     64'd0);
        check({tag, "_pwdata"},    64'(pwdata),    64'd0);
        check({tag, "_pstrb"},     64'(pstrb),     64'd0);
        check({tag, "_pprot"},     64'(pprot),     64'd0);
        check({tag, "_pwrite"},    64'(pwrite),    64'd0);
        check({tag, "_hrdata"},    64'(hrdata),    64'd0);
    endtask

    task automatic idle_bus();
        hsel   = 1'($urandom);
        htrans = 2'($urandom % 2);
        haddr  = 16'($urandom);
        hwrite = 1'($urandom);
        hsize  = 3'($urandom);
        hprot  = 4'($urandom);
    endtask

    // Waits until the bridge can take a new address phase; a NONSEQ offered during ERR2 must be ignored.
    task automatic wait_free();
        int n = 0;
        do begin
            @(negedge hclk);
            n++;
            if (hreadyout && hresp) begin
                idle_bus();
                hsel   = 1'b1;
                htrans = HTRANS_NONSEQ;
            end else begin
                idle_bus();
            end
        end while (!(hreadyout && !hresp) && n < 100);
        check("bridge_free", 64'({hreadyout, hresp}), 64'h2);
    endtask

    task automatic issue(input xfer_t x, input int gap, input bit push, input string name);
        exp_t e;
        int idx, bytes, acc, off;
        bit bad, tmo;
        wait_free();
        repeat (gap) begin
            @(negedge hclk);
            idle_bus();
        end
        idx   = int'(x.addr[13:12]);
        bad   = (idx >= NUM_SLV) || (x.size > 3'd2);
        bytes = 1 << x.size;
        tmo   = !bad && (x.waits >= TIMEOUT_CYC);
        acc   = tmo ? TIMEOUT_CYC : x.waits + 1;
        off   = int'(x.addr[1:0]);
        if (!bad) off = off - (off % bytes);
        e.name     = name;
        e.err      = bad || tmo || x.slverr;
        e.low      = bad ? 1 : (x.write ? 2 : 1) + acc + (e.err ? 1 : 0);
        e.psel     = bad ? 3'b000 : 3'(1 << idx);
        e.psel_cyc = bad ? 0 : acc + 1;
        e.pen_cyc  = bad ? 0 : acc;
        if (!bad && !x.write && !tmo) mdl_hrdata = x.rdata;
        if (!bad && x.write) mdl_pwdata = x.wdata;
        e.hrdata   = mdl_hrdata;
        e.pwdata   = mdl_pwdata;
        e.paddr    = x.addr;
        e.pwrite   = x.write;
        e.chk_strb = !(x.write && x.size > 3'd2);
        e.pstrb    = (x.write && x.size <= 3'd2) ? 4'(((1 << bytes) - 1) << off) : 4'b0000;
        e.pprot    = {~x.prot[0], 1'b0, x.prot[1]};
        cur_idx    = idx;
        cur_waits  = x.waits;
        cur_slverr = x.slverr;
        cur_rdata  = x.rdata;
        hsel   = 1'b1;
        htrans = ($urandom % 2) ? HTRANS_NONSEQ : HTRANS_SEQ;
        haddr  = x.addr;
        hwrite = x.write;
        hsize  = x.size;
        hprot  = x.prot;
        if (push) expq.push_back(e);
        @(negedge hclk);
        idle_bus();
        hwdata = x.wdata;
        @(negedge hclk);
        hwdata = $urandom;
    endtask

    // APB slaves: junk everywhere except the addressed slave during ACCESS.
    initial begin : slave_model
        int k;
        k = 0;
        forever begin
            @(negedge hclk);
            for (int i = 0; i < NUM_SLV; i++) begin
                pready[i]             = 1'($urandom);
                pslverr[i]            = 1'($urandom);
                prdata[i*32 +: 32]    = $urandom;
            end
            if (penable && cur_idx < NUM_SLV) begin
                pready[cur_idx]  = (k == cur_waits);
                pslverr[cur_idx] = (k == cur_waits) ? cur_slverr : 1'($urandom);
                if (k == cur_waits) prdata[cur_idx*32 +: 32] = cur_rdata;
                k++;
            end else begin
                k = 0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        int lowcnt, psel_cyc, pen_cyc;
        logic [2:0] psel_or;
        bit saw_err1;
        lowcnt = 0; psel_cyc = 0; pen_cyc = 0; psel_or = '0; saw_err1 = 0;
        forever begin
            @(negedge hclk);
            if (hreset) begin
                lowcnt = 0; psel_cyc = 0; pen_cyc = 0; psel_or = '0; saw_err1 = 0;
            end else begin
                if (psel != 3'b000) psel_cyc++;
                psel_or = psel_or | psel;
                if (penable) pen_cyc++;
                if (!hreadyout) begin
                    lowcnt++;
                    if (hresp) saw_err1 = 1;
                end else if (lowcnt > 0) begin
                    if (expq.size() == 0) begin
                        check("unexpected_completion_qdepth", 64'(expq.size()), 64'd1);
                    end else begin
                        e = expq.pop_front();
                        check({e.name, "_hresp"},    64'(hresp),    64'(e.err));
                        check({e.name, "_err1"},     64'(saw_err1), 64'(e.err));
                        check({e.name, "_lowcyc"},   64'(lowcnt),   64'(e.low));
                        check({e.name, "_psel"},     64'(psel_or),  64'(e.psel));
                        check({e.name, "_pselcyc"},  64'(psel_cyc), 64'(e.psel_cyc));
                        check({e.name, "_pencyc"},   64'(pen_cyc),  64'(e.pen_cyc));
                        check({e.name, "_hrdata"},   64'(hrdata),   64'(e.hrdata));
                        check({e.name, "_pwdata"},   64'(pwdata),   64'(e.pwdata));
                        check({e.name, "_paddr"},    64'(paddr),    64'(e.paddr));
                        check({e.name, "_pwrite"},   64'(pwrite),   64'(e.pwrite));
                        check({e.name, "_pprot"},    64'(pprot),    64'(e.pprot));
                        if (e.chk_strb) check({e.name, "_pstrb"}, 64'(pstrb), 64'(e.pstrb));
                    end
                    lowcnt = 0; psel_cyc = 0; pen_cyc = 0; psel_or = '0; saw_err1 = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic xfer_t mk(input logic [15:0] addr, input bit write, input logic [2:0] size,
                                 input logic [31:0] wdata, input int waits, input bit slverr,
                                 input logic [31:0] rdata);
        xfer_t x;
        x.addr = addr; x.write = write; x.size = size; x.prot = 4'($urandom);
        x.wdata = wdata; x.waits = waits; x.slverr = slverr; x.rdata = rdata;
        return x;
    endfunction

    initial begin : driver
        xfer_t x;
        int n, idx, bytes;
        repeat (3) @(negedge hclk);
        check_idle("reset");
        hreset = 1'b0;

        issue(mk(16'h2004, 0, 3'd2, 32'h0, 0, 0, 32'hCAFE0001), 2, 1, "rd_2004");
        issue(mk(16'h1003, 1, 3'd0, 32'hAB000000, 0, 0, 32'h0), 1, 1, "wr_byte_1003");
        issue(mk(16'h0010, 0, 3'd2, 32'h0, 5, 1, 32'h12345678), 1, 1, "rd_wait5_slverr");
        issue(mk(16'h1020, 0, 3'd2, 32'h0, 20, 0, 32'hDEADBEEF), 1, 1, "rd_timeout");
        issue(mk(16'h1024, 0, 3'd2, 32'h0, 7, 0, 32'h0BADF00D), 1, 1, "rd_wait7");
        issue(mk(16'h3000, 0, 3'd2, 32'h0, 0, 0, 32'h55555555), 1, 1, "rd_idx3");
        issue(mk(16'h0002, 1, 3'd1, 32'h1234ABCD, 0, 0, 32'h0), 0, 1, "wr_half_b2b");
        issue(mk(16'h0008, 0, 3'd3, 32'h0, 0, 0, 32'h0), 1, 1, "rd_size3");
        issue(mk(16'h2040, 0, 3'd2, 32'h0, 0, 0, 32'hA5A5A5A5), 1, 1, "rd_a");
        issue(mk(16'h2044, 0, 3'd2, 32'h0, 0, 0, 32'h5A5A5A5A), 0, 1, "rd_b2b");
        issue(mk(16'h1100, 1, 3'd2, 32'hFEEDFACE, 0, 0, 32'h0), 0, 1, "wr_b2b");

        for (int t = 0; t < 60; t++) begin
            x.write  = 1'($urandom);
            x.size   = ($urandom % 8 == 0) ? 3'(3 + $urandom % 5) : 3'($urandom % 3);
            idx      = ($urandom % 8 == 0) ? 3 : int'($urandom % 3);
            bytes    = (x.size <= 3'd2) ? (1 << x.size) : 1;
            x.addr   = 16'($urandom);
            x.addr[13:12] = 2'(idx);
            x.addr[1:0]   = 2'(($urandom % 4) & ~(bytes - 1));
            x.prot   = 4'($urandom);
            x.wdata  = $urandom;
            x.rdata  = $urandom;
            x.waits  = ($urandom % 10 == 0) ? 8 + int'($urandom % 4) : int'($urandom % 4);
            x.slverr = ($urandom % 6 == 0);
            issue(x, int'($urandom % 3), 1, $sformatf("rand%0d", t));
        end

        issue(mk(16'h1008, 0, 3'd2, 32'h0, 5, 0, 32'h77777777), 1, 0, "rd_abort");
        n = 0;
        while (!penable && n < 20) begin
            @(negedge hclk);
            n++;
        end
        check("abort_in_access", 64'(penable), 64'd1);
        hreset = 1'b1;
        @(negedge hclk);
        check_idle("abort");
        @(negedge hclk);
        hreset = 1'b0;
        mdl_hrdata = '0;
        mdl_pwdata = '0;

        issue(mk(16'h2008, 1, 3'd2, 32'h0F0F0F0F, 1, 0, 32'h0), 1, 1, "post_rst_wr");
        issue(mk(16'h200C, 0, 3'd2, 32'h0, 2, 0, 32'h31415926), 0, 1, "post_rst_rd");

        wait_free();
        repeat (3) @(negedge hclk);
        check("scoreboard_empty", 64'(expq.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
